// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - queues segment durations and arms the load/expire timer one segment at a time
// Clears the timer's sticky expiry through tmr_clr_n before every load; all outputs are flops.
module timer_sequencer #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic                     timer_clock,
   input  logic                     timer_rstn,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   output logic                     push_ovf,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   output logic                     seg_done,
   output logic                     all_done,
   output logic                     tmr_clr_n,
   output logic                     tmr_load,
   output logic [DATA_W-1:0]        tmr_data,
   input  logic                     tmr_expired
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_LVL = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   LVL_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LOAD,
      S_RUN,
      S_SEG,
      S_ABT
   } state_t;

   state_t            state;
   state_t            nstate;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              pop;
   logic              wr_en;
   logic [PTR_W:0]    level_nxt;

   // In SEG the registered all_done flag decides the exit, so the pulse and the branch always agree.
   always_comb begin
      nstate = state;
      if (abort) begin
         nstate = S_ABT;
      end else begin
         case (state)
            S_IDLE:  if (start && level != '0) nstate = S_CLR;
            S_CLR:   nstate = S_LOAD;
            S_LOAD:  nstate = S_RUN;
            S_RUN:   if (tmr_expired) nstate = S_SEG;
            S_SEG:   nstate = all_done ? S_IDLE : S_CLR;
            S_ABT:   nstate = S_IDLE;
            default: nstate = S_IDLE;
         endcase
      end
   end

   assign pop   = (nstate == S_CLR);
   assign wr_en = push && !abort && (!full || pop);

   always_comb begin
      level_nxt = level;
      if (abort) begin
         level_nxt = '0;
      end else begin
         case ({wr_en, pop})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
         endcase
      end
   end

   always_ff @(posedge timer_clock) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge timer_clock or negedge timer_rstn) begin
      if (!timer_rstn) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         full      <= 1'b0;
         push_ovf  <= 1'b0;
         busy      <= 1'b0;
         seg_done  <= 1'b0;
         all_done  <= 1'b0;
         tmr_clr_n <= 1'b0;
         tmr_load  <= 1'b0;
         tmr_data  <= '0;
      end else begin
         state    <= nstate;
         level    <= level_nxt;
         full     <= (level_nxt == FULL_LVL);
         push_ovf <= push && !abort && full && !pop;
         if (nstate == S_ABT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (pop) tmr_data <= mem[rd_ptr];
         // Decoded from next state so tmr_clr_n never sees a combinational glitch.
         busy      <= (nstate != S_IDLE);
         tmr_clr_n <= !((nstate == S_CLR) || (nstate == S_ABT));
         tmr_load  <= (nstate == S_LOAD);
         seg_done  <= (nstate == S_SEG);
         all_done  <= (nstate == S_SEG) && (level_nxt == '0);
      end
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - scoreboard bench for timer_sequencer with a FREQ=5 load/expire timer model
module tb_timer_sequencer;

   localparam int DATA_W = 10;
   localparam int DEPTH  = 4;
   localparam int FREQ   = 5;

   logic              timer_clock = 1'b0;
   logic              timer_rstn  = 1'b0;
   logic              push        = 1'b0;
   logic [DATA_W-1:0] push_data   = '0;
   logic              start       = 1'b0;
   logic              abort       = 1'b0;
   logic              push_ovf;
   logic              full;
   logic [2:0]        level;
   logic              busy;
   logic              seg_done;
   logic              all_done;
   logic              tmr_clr_n;
   logic              tmr_load;
   logic [DATA_W-1:0] tmr_data;
   logic              tmr_expired;

   logic              model_exp;
   logic              force_exp = 1'b0;
   int                cnt;
   bit                running;

   typedef struct {
      int kind;   // 0 load, 1 seg_done, 2 push_ovf
      int val;    // tmr_data for loads, all_done for seg_done
   } ev_t;
   ev_t exp_q[$];

   int  checks = 0;
   int  errors = 0;
   bit  prev1_clr;
   bit  prev2_clr;
   int  run_cnt;

   timer_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .timer_clock(timer_clock),
      .timer_rstn (timer_rstn),
      .push       (push),
      .push_data  (push_data),
      .push_ovf   (push_ovf),
      .full       (full),
      .level      (level),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .seg_done   (seg_done),
      .all_done   (all_done),
      .tmr_clr_n  (tmr_clr_n),
      .tmr_load   (tmr_load),
      .tmr_data   (tmr_data),
      .tmr_expired(tmr_expired)
   );

   always #5 timer_clock = ~timer_clock;

   // Timer: load d, expire d*FREQ+1 cycles later, sticky until cleared.
   always @(posedge timer_clock or negedge tmr_clr_n) begin
      if (!tmr_clr_n) begin
         model_exp <= 1'b0;
         cnt       <= 0;
         running   <= 1'b0;
      end else if (tmr_load) begin
         cnt     <= int'(tmr_data) * FREQ;
         running <= 1'b1;
      end else if (running) begin
         if (cnt == 0) begin
            model_exp <= 1'b1;
            running   <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end
   assign tmr_expired = model_exp | force_exp;

   task automatic check(input string name, input logic [31:0] act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic expect_ev(input int kind, input int val, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected event value %0d, expected no event", name, val);
      end else begin
         e = exp_q.pop_front();
         check({name, "_kind"}, kind, e.kind);
         check({name, "_val"}, val, e.val);
      end
   endtask

   task automatic exp_push(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Monitor: pops the scoreboard for each DUT event and checks timing relative to clr/expiry.
   always @(negedge timer_clock) begin
      if (!timer_rstn) begin
         prev1_clr = 1'b0;
         prev2_clr = 1'b0;
         run_cnt   = 0;
      end else begin
         if (push_ovf) expect_ev(2, 0, "ovf");
         if (tmr_load) begin
            expect_ev(0, int'(tmr_data), "load");
            check("clr_before_load", {30'd0, prev2_clr, prev1_clr}, 2);
         end
         if (seg_done) begin
            expect_ev(1, int'(all_done), "seg");
            check("seg_latency", run_cnt, 1);
            run_cnt = 0;
         end else if (busy && tmr_clr_n && !tmr_load) begin
            if (tmr_expired) run_cnt++;
         end else begin
            run_cnt = 0;
         end
         if (all_done) check("all_done_with_seg", seg_done, 1);
         prev2_clr = prev1_clr;
         prev1_clr = tmr_clr_n;
      end
   end

   task automatic tick();
      @(posedge timer_clock);
      #1;
   endtask

   task automatic do_push(input int v);
      push      = 1'b1;
      push_data = DATA_W'(v);
      tick();
      push      = 1'b0;
   endtask

   task automatic wait_all_done(input int lim, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (all_done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: all_done not seen within %0d cycles", name, lim);
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_clr_n", tmr_clr_n, 0);
      check("rst_busy", busy, 0);
      check("rst_level", level, 0);
      check("rst_full", full, 0);
      check("rst_load", tmr_load, 0);
      timer_rstn = 1'b1;
      #1;
      check("clr_n_before_edge", tmr_clr_n, 0);
      tick();
      check("clr_n_after_edge", tmr_clr_n, 1);

      // Two segments: 3 then 2
      do_push(3);
      do_push(2);
      check("t1_level", level, 2);
      exp_push(0, 3); exp_push(1, 0); exp_push(0, 2); exp_push(1, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_clr_cycle", tmr_clr_n, 0);
      check("t1_busy", busy, 1);
      check("t1_level_pop", level, 1);
      tick();
      check("t1_clr_one_cycle", tmr_clr_n, 1);
      wait_all_done(200, "t1_done");
      tick();
      check("t1_busy_after", busy, 0);
      check("t1_level_after", level, 0);

      // Fill, overflow, run four segments in order
      for (int i = 1; i <= 4; i++) do_push(i);
      check("t2_full", full, 1);
      check("t2_level4", level, 4);
      exp_push(2, 0);
      do_push(5);
      check("t2_level_ovf", level, 4);
      check("t2_full_ovf", full, 1);
      tick();
      for (int i = 1; i <= 4; i++) begin
         exp_push(0, i);
         exp_push(1, (i == 4) ? 1 : 0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_all_done(400, "t2_done");
      tick();
      check("t2_level_after", level, 0);
      check("t2_busy_after", busy, 0);

      // Start with empty queue
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t3_busy0", busy, 0);
      tick();
      check("t3_busy1", busy, 0);
      check("t3_load", tmr_load, 0);

      // Abort during RUN of the first of three, with a same-cycle push
      do_push(1); do_push(2); do_push(3);
      exp_push(0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      abort     = 1'b1;
      push      = 1'b1;
      push_data = 10'd7;
      tick();
      abort = 1'b0;
      push  = 1'b0;
      check("t4_abt_clr_n", tmr_clr_n, 0);
      check("t4_abt_busy", busy, 1);
      check("t4_abt_level", level, 0);
      check("t4_abt_seg", seg_done, 0);
      tick();
      check("t4_idle_busy", busy, 0);
      check("t4_idle_clr_n", tmr_clr_n, 1);
      check("t4_idle_level", level, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_restart_ignored", busy, 0);
      tick();

      // Stale expiry during IDLE/CLR/LOAD, zero-duration segment
      do_push(0);
      exp_push(0, 0); exp_push(1, 1);
      start     = 1'b1;
      force_exp = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      force_exp = 1'b0;
      wait_all_done(50, "t5_done");
      tick();
      check("t5_busy_after", busy, 0);

      // Push and pop in the same cycle while full
      for (int i = 0; i < 4; i++) do_push(1);
      exp_push(0, 1);
      push      = 1'b1;
      push_data = 10'd9;
      start     = 1'b1;
      tick();
      push  = 1'b0;
      start = 1'b0;
      check("t6_level", level, 4);
      check("t6_full", full, 1);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t6_abt_level", level, 0);
      check("t6_abt_full", full, 0);
      tick();

      // Asynchronous reset mid-RUN
      do_push(4);
      exp_push(0, 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      timer_rstn = 1'b0;
      #1;
      check("t7_rst_clr_n", tmr_clr_n, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_level", level, 0);
      tick();
      tick();
      timer_rstn = 1'b1;
      #1;
      check("t7_clr_n_held", tmr_clr_n, 0);
      tick();
      check("t7_clr_n_release", tmr_clr_n, 1);
      check("t7_busy_release", busy, 0);
      tick();
      tick();

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Upstream controller for the team's load/expire timer (timer_clock, timer_rstn, timer_load, timer_data, timer_out).
- Holds a small queue of segment durations and arms the timer with one segment at a time.
- Before each load it clears the timer's sticky expiry flag through the timer's reset input. It reports per-segment and end-of-sequence completion.
- Instantiated directly beside the timer: its tmr_* outputs drive the timer, and the timer's output returns on tmr_expired.

Parameters:
- DATA_W, 10, width of one duration word; must equal the timer's data width.
- DEPTH, 4, queue entries; power of 2, at least 2.

Ports:
- timer_clock  in  1  sole clock, rising edge.
- timer_rstn  in  1  asynchronous active-low reset.
- push  in  1  enqueue push_data this cycle.
- push_data  in  DATA_W  segment duration in timer units.
- push_ovf  out  1  one-cycle pulse: push attempted while full; word dropped.
- full  out  1  queue holds DEPTH entries.
- level  out  clog2(DEPTH)+1  current queue occupancy.
- start  in  1  begin running the queued segments.
- abort  in  1  stop the sequence and flush the queue.
- busy  out  1  high in every state except IDLE.
- seg_done  out  1  one-cycle pulse per expired segment.
- all_done  out  1  one-cycle pulse when the final segment expires.
- tmr_clr_n  out  1  drives the timer reset; active-low.
- tmr_load  out  1  drives the timer load.
- tmr_data  out  DATA_W  drives the timer data.
- tmr_expired  in  1  timer output; sticky high until the timer is cleared.

Behaviour:
- Reset values:
  - All outputs 0, including tmr_clr_n, so the timer is held cleared during reset.
  - State IDLE, queue empty, level 0.
- tmr_clr_n goes to 1 at the first clock edge after reset is released.
- All outputs come from flops; they are decoded from next-state so each is valid for the whole cycle its state is occupied. No combinational path is allowed to tmr_clr_n, because it feeds an asynchronous reset.
- Queue:
  - Synchronous FIFO with read and write pointers that wrap modulo DEPTH.
  - Push while full: word dropped, level unchanged, push_ovf pulses.
  - A push and a pop in the same cycle while full are both accepted; level stays unchanged.
  - Pops happen only in CLR.
- FSM:
  - IDLE:
    - start with level>0 goes to CLR.
    - start with level==0 is ignored.
    - start is evaluated against the level before any same-cycle push.
  - CLR (1 cycle): tmr_clr_n=0; head word is latched into the tmr_data register and popped. Next state LOAD.
  - LOAD (1 cycle): tmr_load=1; tmr_data holds the latched word, and keeps it until the next CLR. Next state RUN.
  - RUN: wait for tmr_expired==1. On the first cycle it is sampled high, go to SEG.
  - SEG (1 cycle): seg_done=1.
    - If level>0, next state CLR, with no idle gap.
    - Otherwise all_done=1 in this same cycle, and next state IDLE.
- tmr_expired is ignored in every state except RUN.
- Latency:
  - start sampled at edge N: CLR in cycle N+1, LOAD in N+2, RUN from N+3.
  - tmr_expired high at edge M (in RUN): seg_done in cycle M+1.
- abort:
  - Priority over start, push and tmr_expired in every state.
  - Next state ABT (1 cycle): tmr_clr_n=0, queue flushed (level 0), no seg_done or all_done. Next state IDLE.
  - abort in IDLE still performs ABT; busy is high during ABT.
  - A push in the same cycle as abort is discarded.
- A zero duration is legal and passed through unchanged; completion depends only on tmr_expired.
- Asynchronous reset mid-sequence: immediate return to reset values; no completion pulse.

Test Plan:
- Reset, then push 3 and push 2 (level=2), then start; timer model with FREQ=5 attached.
  - Expected: tmr_clr_n low exactly 1 cycle, then tmr_load with tmr_data=3.
  - seg_done 1 cycle after tmr_expired rises; immediately CLR, then load of 2.
  - second seg_done coincides with all_done; busy falls the following cycle; level=0.
- Push 4 words into DEPTH=4, then a 5th push.
  - Expected: full=1, push_ovf pulses once, level stays 4.
  - Start runs exactly 4 segments in push order, with tmr_data 1,2,3,4.
- Start with empty queue.
  - Expected: busy stays 0, tmr_load never asserts, no pulses.
- Abort during RUN of the first of 3 segments.
  - Expected: next cycle ABT with tmr_clr_n=0, then IDLE, level=0, no seg_done.
  - A later start is ignored.
- tmr_expired forced high during CLR and LOAD (stale flag).
  - Expected: no seg_done until tmr_expired is sampled high in RUN.
  - A zero-duration segment (push 0) completes normally.
- Assert timer_rstn mid-RUN.
  - Expected: tmr_clr_n, busy, level all 0 immediately; tmr_clr_n returns to 1 on the first edge after release.
